// File: rtl/svga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// svga_timing_gen_if
//
// Bundle between the SVGA timing/fetch stage and its surroundings (pixel
// source on one side, DVI output pins on the other).
//
// Parameters:
//   H_VISIBLE / V_VISIBLE : active area; they size the fetch coordinates.
//
// Signals:
//   pix_ce                  pixel step enable
//   fetch_x, fetch_y        lookahead coordinate handed to the pixel source
//   fetch_valid             fetch coordinate lies in the visible area
//   line_start, frame_start one-clk pulses on the fetch side
//   pix_r/g/b               4-bit RGB returned by the pixel source
//   dvi_hsync/vsync/de      aligned DVI sync and data enable
//   dvi_r/g/b               aligned DVI colour, zero while blanking
//
// Modports:
//   master : the timing generator
//   slave  : the environment (pixel source + DVI sink + step-enable driver)
// ---------------------------------------------------------------------------
interface svga_timing_gen_if #(
  parameter int H_VISIBLE = 800,
  parameter int V_VISIBLE = 600
);
  localparam int X_W = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
  localparam int Y_W = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;

  logic           pix_ce;
  logic [X_W-1:0] fetch_x;
  logic [Y_W-1:0] fetch_y;
  logic           fetch_valid;
  logic           line_start;
  logic           frame_start;
  logic [3:0]     pix_r;
  logic [3:0]     pix_g;
  logic [3:0]     pix_b;
  logic           dvi_hsync;
  logic           dvi_vsync;
  logic           dvi_de;
  logic [3:0]     dvi_r;
  logic [3:0]     dvi_g;
  logic [3:0]     dvi_b;

  modport master (
    input  pix_ce, pix_r, pix_g, pix_b,
    output fetch_x, fetch_y, fetch_valid, line_start, frame_start,
    output dvi_hsync, dvi_vsync, dvi_de, dvi_r, dvi_g, dvi_b
  );

  modport slave (
    output pix_ce, pix_r, pix_g, pix_b,
    input  fetch_x, fetch_y, fetch_valid, line_start, frame_start,
    input  dvi_hsync, dvi_vsync, dvi_de, dvi_r, dvi_g, dvi_b
  );
endinterface

// File: rtl/svga_timing_gen.sv
// ---------------------------------------------------------------------------
// svga_timing_gen
//
// Pixel/line counters, lookahead fetch coordinates and DVI re-alignment for
// the SVGA generator. The fetch coordinate is the counter itself; the sync
// and data-enable derived from it are delayed LATENCY pixel steps so they
// leave on the same registered edge as the RGB returned by the source.
//
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : svga_timing_gen_if.master (step enable, fetch side, DVI side)
//
// All state advances only on clocks where bus.pix_ce is high; the
// line_start/frame_start pulses are the exception and always fall after a
// single clk.
// ---------------------------------------------------------------------------
module svga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BACK    = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BACK    = 23,
  parameter bit HSYNC_POL = 1'b1,
  parameter bit VSYNC_POL = 1'b1,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              reset,
  svga_timing_gen_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int FX_W    = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
  localparam int FY_W    = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;

  // The last pipeline stage is the DVI output register itself, so the
  // shift register proper holds LATENCY-1 stages (at least one flop).
  localparam int DLY     = (LATENCY > 1) ? LATENCY - 1 : 1;
  localparam int TAP     = (LATENCY > 1) ? LATENCY - 2 : 0;

  localparam int H_LAST  = H_TOTAL - 1;
  localparam int V_LAST  = V_TOTAL - 1;
  localparam int HS_LO   = H_VISIBLE + H_FRONT;
  localparam int HS_HI   = HS_LO + H_SYNC;
  localparam int VS_LO   = V_VISIBLE + V_FRONT;
  localparam int VS_HI   = VS_LO + V_SYNC;

  // Window bounds are one bit wider than the counters so an end bound equal
  // to TOTAL (zero back porch) does not wrap to zero.
  localparam logic [HW:0]   H_VIS_C  = H_VISIBLE[HW:0];
  localparam logic [HW:0]   HS_LO_C  = HS_LO[HW:0];
  localparam logic [HW:0]   HS_HI_C  = HS_HI[HW:0];
  localparam logic [VW:0]   V_VIS_C  = V_VISIBLE[VW:0];
  localparam logic [VW:0]   VS_LO_C  = VS_LO[VW:0];
  localparam logic [VW:0]   VS_HI_C  = VS_HI[VW:0];
  localparam logic [HW-1:0] H_LAST_C = H_LAST[HW-1:0];
  localparam logic [VW-1:0] V_LAST_C = V_LAST[VW-1:0];

  logic [HW-1:0]  hcnt_q, hcnt_d;
  logic [VW-1:0]  vcnt_q, vcnt_d;
  logic           fetch_valid_q, fetch_valid_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;
  logic           raw_hsync, raw_vsync;
  logic [DLY-1:0] hs_sr_q, vs_sr_q, de_sr_q;
  logic           tap_hs, tap_vs, tap_de;
  logic           dvi_hsync_q, dvi_vsync_q, dvi_de_q;
  logic [3:0]     dvi_r_q, dvi_g_q, dvi_b_q;

  // Next counter state: wrap hcnt at H_TOTAL-1 and advance vcnt on the wrap.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (bus.pix_ce) begin
      if (hcnt_q == H_LAST_C) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST_C) begin
          vcnt_d = '0;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
      end
    end else begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
    end
  end

  // Fetch-side flags for the counter state about to be entered.
  always_comb begin
    fetch_valid_d = ({1'b0, hcnt_d} < H_VIS_C) && ({1'b0, vcnt_d} < V_VIS_C);
    line_start_d  = bus.pix_ce && (hcnt_d == '0) && ({1'b0, vcnt_d} < V_VIS_C);
    frame_start_d = bus.pix_ce && (hcnt_d == '0) && (vcnt_d == '0);
  end

  // Raw sync levels for the coordinate currently being fetched.
  always_comb begin
    if (({1'b0, hcnt_q} >= HS_LO_C) && ({1'b0, hcnt_q} < HS_HI_C)) begin
      raw_hsync = HSYNC_POL;
    end else begin
      raw_hsync = ~HSYNC_POL;
    end
    if (({1'b0, vcnt_q} >= VS_LO_C) && ({1'b0, vcnt_q} < VS_HI_C)) begin
      raw_vsync = VSYNC_POL;
    end else begin
      raw_vsync = ~VSYNC_POL;
    end
  end

  // Stage feeding the output registers: LATENCY-1 steps old, or the raw
  // value when the source answers within a single step. fetch_valid_q is
  // the raw data enable of the current coordinate.
  always_comb begin
    if (LATENCY > 1) begin
      tap_hs = hs_sr_q[TAP];
      tap_vs = vs_sr_q[TAP];
      tap_de = de_sr_q[TAP];
    end else begin
      tap_hs = raw_hsync;
      tap_vs = raw_vsync;
      tap_de = fetch_valid_q;
    end
  end

  // Counters, fetch flags, delay line and DVI output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      fetch_valid_q <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_sr_q       <= {DLY{~HSYNC_POL}};
      vs_sr_q       <= {DLY{~VSYNC_POL}};
      de_sr_q       <= '0;
      dvi_hsync_q   <= ~HSYNC_POL;
      dvi_vsync_q   <= ~VSYNC_POL;
      dvi_de_q      <= 1'b0;
      dvi_r_q       <= 4'h0;
      dvi_g_q       <= 4'h0;
      dvi_b_q       <= 4'h0;
    end else begin
      // Pulses already include pix_ce, so they fall on the next clk.
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      if (bus.pix_ce) begin
        hcnt_q        <= hcnt_d;
        vcnt_q        <= vcnt_d;
        fetch_valid_q <= fetch_valid_d;
        hs_sr_q[0]    <= raw_hsync;
        vs_sr_q[0]    <= raw_vsync;
        de_sr_q[0]    <= fetch_valid_q;
        for (int i = 1; i < DLY; i++) begin
          hs_sr_q[i] <= hs_sr_q[i-1];
          vs_sr_q[i] <= vs_sr_q[i-1];
          de_sr_q[i] <= de_sr_q[i-1];
        end
        dvi_hsync_q <= tap_hs;
        dvi_vsync_q <= tap_vs;
        dvi_de_q    <= tap_de;
        // RGB arriving now belongs to the pixel whose de is at the tap.
        dvi_r_q     <= tap_de ? bus.pix_r : 4'h0;
        dvi_g_q     <= tap_de ? bus.pix_g : 4'h0;
        dvi_b_q     <= tap_de ? bus.pix_b : 4'h0;
      end
    end
  end

  assign bus.fetch_x     = hcnt_q[FX_W-1:0];
  assign bus.fetch_y     = vcnt_q[FY_W-1:0];
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.dvi_hsync   = dvi_hsync_q;
  assign bus.dvi_vsync   = dvi_vsync_q;
  assign bus.dvi_de      = dvi_de_q;
  assign bus.dvi_r       = dvi_r_q;
  assign bus.dvi_g       = dvi_g_q;
  assign bus.dvi_b       = dvi_b_q;

endmodule

// File: doc/svga_timing_gen.md
# svga_timing_gen

Pixel timing and fetch-pipeline stage that sits directly upstream of the DVI output pins in the SVGA generator. It produces the pixel and line counters, issues lookahead fetch coordinates to the pixel source (framebuffer or character generator), and re-aligns the returned 4-bit RGB with sync and data-enable so all DVI signals leave on the same registered edge. Default timing is 800x600@60 with a 40 MHz pixel rate.

## Interface
- H_VISIBLE, 800, active pixels per line
- H_FRONT, 40, horizontal front porch (pixels)
- H_SYNC, 128, hsync width (pixels)
- H_BACK, 88, horizontal back porch (pixels)
- V_VISIBLE, 600, active lines per frame
- V_FRONT, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BACK, 23, vertical back porch (lines)
- HSYNC_POL, 1, hsync asserted level
- VSYNC_POL, 1, vsync asserted level
- LATENCY, 2, pixel-source latency in pixel steps (1..8)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_ce  in  1  pixel step enable; all state advances only when high
- fetch_x  out  clog2(H_VISIBLE)  column being fetched
- fetch_y  out  clog2(V_VISIBLE)  line being fetched
- fetch_valid  out  1  fetch_x/fetch_y lie in the visible area
- line_start  out  1  one-clk pulse, first visible pixel of a line on the fetch side
- frame_start  out  1  one-clk pulse, fetch of pixel (0,0)
- pix_r, pix_g, pix_b  in  4 each  RGB returned by pixel source
- dvi_hsync  out  1  horizontal sync
- dvi_vsync  out  1  vertical sync
- dvi_de  out  1  data enable
- dvi_r, dvi_g, dvi_b  out  4 each  RGB, forced 0 when dvi_de low

## Operation
- H_TOTAL = sum of H_*, V_TOTAL = sum of V_* (defaults 1056, 628). Counters hcnt 0..H_TOTAL-1, vcnt 0..V_TOTAL-1.
- On pix_ce: hcnt increments; at H_TOTAL-1 it wraps to 0 and vcnt increments; vcnt wraps from V_TOTAL-1 to 0 simultaneously with hcnt wrap.
- Visible region: hcnt < H_VISIBLE and vcnt < V_VISIBLE. fetch_x = hcnt, fetch_y = vcnt (direct register outputs, no extra stage); values outside visible region are don't-care for the source but fetch_valid = 0.
- Raw hsync active for H_VISIBLE+H_FRONT <= hcnt < H_VISIBLE+H_FRONT+H_SYNC; raw vsync likewise on vcnt. Driven at HSYNC_POL/VSYNC_POL when active, inverted level otherwise.
- Raw hsync, vsync, de go through a LATENCY-deep shift register advancing on pix_ce.
- Pixel source contract: for coordinate presented during step n, RGB is valid on pix_r/g/b during step n+LATENCY-1. Output registers capture it at end of that step; dvi_* for that pixel are visible during step n+LATENCY.
- dvi_r/g/b = delayed de ? pix : 0.
- line_start: one clk pulse when pix_ce and next counter state is (hcnt=0, vcnt<V_VISIBLE). frame_start: same condition with vcnt=0. Both gated by pix_ce, never longer than one clk.

## Timing
- Reset (async, any time): hcnt=vcnt=0, fetch_valid=1 after release (counter at (0,0) is visible), line_start=frame_start=0, all delay stages cleared to deasserted sync level and de=0, dvi_hsync=!HSYNC_POL, dvi_vsync=!VSYNC_POL, dvi_de=0, dvi_rgb=0.
- First pix_ce after reset release renders pixel (0,0) fetch; first dvi_de=1 appears LATENCY steps after that step.
- pix_ce low: every register holds, including pulses (they drop after one clk).
- Reset mid-frame: immediate restart at (0,0); no partial sync pulse stretched; pipeline flushed to blanking.
- Counter widths sized for H_TOTAL/V_TOTAL; no overflow past TOTAL-1 under any parameter set.

## Test plan
- Small params (H 8/2/2/2, V 4/1/1/1, LATENCY=2, pix_ce=1): hcnt period 14 clks, vsync period 98 clks; hsync high for hcnt 10..11 delayed by 2 clks.
- Source model returns pix_r = fetch_x[3:0] with 1-step latency: dvi_r sequence 0..7 during dvi_de, 0 in blanking; dvi_de high exactly 8 clks per visible line, 4 lines/frame.
- pix_ce every 3rd clk: all output periods scale by 3; line_start/frame_start remain 1 clk wide; frame_start once per 294 clks.
- Assert reset at hcnt=5, vcnt=2 for 1 clk: outputs go to reset values asynchronously; after release fetch restarts at (0,0), frame_start fires on next wrap sequence without glitch.
- HSYNC_POL=0, VSYNC_POL=0: idle levels 1 during reset and outside sync windows, 0 inside.
- Default 800x600: 1056x628 = 663168 pix steps per frame; dvi_de high 480000 steps per frame.
